spectrum_frame_sched: RTL and testbench
=======================================

// Module: spectrum_frame_sched
// PURPOSE
//  Frame-synchronous scheduler between the FFT bin stream and the VGA bar renderer.
//  Collects N_BARS signed bins into a back bank and converts each bin to a clamped bar height.
//  Swaps banks only at vblank start, so a frame never tears.
//  After each swap, runs a per-bar peak-hold/decay pass.
//  Renderer reads bar and peak heights by index with 1-cycle latency.
// PARAMETERS
//  N_BARS     32   bars per frame (power of 2)
//  BIN_W      24   signed bin width
//  H_W        10   height width
//  MAX_H      479  height clamp (active lines - 1)
//  SHIFT      5    bin -> height right shift
//  DECAY      4    peak decrement per frame, saturating at 0
// PORTS
//  i_clk         in   1       pixel clock
//  reset         in   1       synchronous, active-high
//  s_valid       in   1       bin valid
//  s_ready       out  1       bin accepted when s_valid&&s_ready
//  s_bin         in   BIN_W   signed bin value
//  s_last        in   1       marks last bin of a set
//  i_frame_start in   1       1-cycle pulse at first vblank line
//  i_bar_idx     in   5       read index (log2 N_BARS)
//  o_bar_height  out  H_W     front-bank height[i_bar_idx], registered
//  o_peak_height out  H_W     peak[i_bar_idx], registered
//  o_committed   out  1       pulse: banks swapped this cycle
//  o_stale       out  1       pulse: frame_start arrived without a complete set
//  o_seq_err     out  1       pulse: s_last/index mismatch, set discarded
// BEHAVIOUR
//  Reset, on the clock edge: state=FILL, idx=0, bank=0, all heights/peaks=0, all outputs 0.
//  Reset mid-operation discards any partial set.
//  Conversion: h = (bin<0) ? 0 : min(bin>>>SHIFT, MAX_H). Computed on accept.
//  The converted height is written to back[idx].
//  States:
//   FILL : s_ready=1. On accept, write back[idx] and idx++.
//          s_last with idx<N_BARS-1 -> o_seq_err, idx=0, stay FILL.
//          Accept at idx==N_BARS-1 -> READY. The set is taken even if s_last=0, with o_seq_err pulsed.
//          i_frame_start in FILL -> o_stale; front bank unchanged.
//   READY: s_ready=0. Waits for i_frame_start, then SWAP.
//   SWAP : 1 cycle. bank toggles, o_committed=1, pidx=0.
//   PEAK : 1 bar/cycle for N_BARS cycles: peak[p] = max(front[p], sat0(peak[p]-DECAY)).
//          Then idx=0 -> FILL.
//  Simultaneous final accept and i_frame_start: the edge sees FILL, so o_stale=1 and no swap.
//  In that case the swap happens at the next frame_start.
//  i_frame_start during SWAP/PEAK is ignored; no flag is raised.
//  Read port: o_*_height <= array[i_bar_idx]. Latency is exactly 1 cycle in every state.
//  During PEAK a read of bar p returns either the old or the new peak, never a mix.
//  s_bin is treated as signed; the shift is arithmetic. The clamp happens before truncation to H_W.
// STRUCTURE
//  vis_pkg: N_BARS, H_W, MAX_H, sched_state_e {FILL,READY,SWAP,PEAK}, function bin_to_height().
//  Sub-module bar_bank_rf: 2xN_BARS x H_W register file.
//   It has one write port (back bank), a bank-select input and a registered read port (front bank).
//  The peak array and the FSM stay in this module.
// TESTING
//  1. 32 bins of value 0x003C00 (15360), s_last on bin 31, then frame_start.
//     -> o_committed one cycle after; every bar reads 480 clamped to 479 (0x1DF).
//  2. bin=-1000 and bin=0x7FFFFF.
//     -> heights 0 and 479; bin=3200 -> 100.
//  3. frame_start after 20 bins accepted.
//     -> o_stale=1, heights unchanged.
//     After bin 31 and the next frame_start -> swap.
//  4. s_last on bin 9.
//     -> o_seq_err=1; the next full set of 32 fills from idx 0 and commits.
//  5. Bar 0 =400, then 100 for 3 frames.
//     -> peak 400, 396, 392, 388; with DECAY=4 and peak 2 -> 0 (saturate, no wrap).
//  6. reset asserted during PEAK at pidx=10.
//     -> next cycle state FILL, s_ready=1, all reads 0.

Source files
------------

// File: rtl/spectrum_frame_sched_pkg.sv
// Shared definitions for the spectrum frame scheduler.
// Contents: frame geometry constants, scheduler state enum, and the
// bin->height and peak-decay helper functions.
package spectrum_frame_sched_pkg;

  localparam int N_BARS = 32;
  localparam int IDX_W  = $clog2(N_BARS);
  localparam int BIN_W  = 24;
  localparam int H_W    = 10;
  localparam int MAX_H  = 479;
  localparam int SHIFT  = 5;
  localparam int DECAY  = 4;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    READY = 2'd1,
    SWAP  = 2'd2,
    PEAK  = 2'd3
  } sched_state_e;

  // Negative bins draw nothing. The clamp is applied on the full-width shifted
  // value, so large bins saturate instead of wrapping when cut to H_W bits.
  function automatic logic [H_W-1:0] bin_to_height(input logic signed [BIN_W-1:0] b);
    logic signed [BIN_W-1:0] sh;
    sh = b >>> SHIFT;
    if (b < 0)
      return '0;
    else if (sh > $signed(BIN_W'(MAX_H)))
      return H_W'(MAX_H);
    else
      return sh[H_W-1:0];
  endfunction

  // Peak falls by DECAY per frame, floors at 0, and is pushed up by the new bar.
  function automatic logic [H_W-1:0] peak_next(input logic [H_W-1:0] bar,
                                               input logic [H_W-1:0] peak);
    logic [H_W-1:0] dec;
    dec = (peak > H_W'(DECAY)) ? peak - H_W'(DECAY) : '0;
    return (bar > dec) ? bar : dec;
  endfunction

endpackage

// File: rtl/spectrum_frame_sched_if.sv
// Bin stream interface from the FFT into the frame scheduler.
// Signals: valid, ready, bin (signed), last (final bin of a set).
// Handshake: a bin transfers on a clock edge where valid && ready are both 1.
// The master holds bin/last stable while valid is high and not yet accepted;
// ready may change in any cycle and does not depend on valid.
interface spectrum_frame_sched_if;
  import spectrum_frame_sched_pkg::*;

  logic                    valid;
  logic                    ready;
  logic signed [BIN_W-1:0] bin;
  logic                    last;

  modport master (output valid, output bin, output last, input ready);
  modport slave  (input valid, input bin, input last, output ready);
endinterface

// File: rtl/spectrum_frame_sched_bar_bank_rf.sv
// Double-banked bar height register file.
// Ports: i_clk, reset (sync, active-high); front_sel picks the front bank;
// we/waddr/wdata write the back bank; raddr->rdata is the registered renderer
// read of the front bank; paddr->pdata is a combinational front-bank read
// used by the peak pass.
module spectrum_frame_sched_bar_bank_rf
  import spectrum_frame_sched_pkg::*;
(
  input  logic             i_clk,
  input  logic             reset,
  input  logic             front_sel,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [H_W-1:0]   wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [H_W-1:0]   rdata,
  input  logic [IDX_W-1:0] paddr,
  output logic [H_W-1:0]   pdata
);

  logic [H_W-1:0] mem [2][N_BARS];

  always_ff @(posedge i_clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < N_BARS; i++)
          mem[b][i] <= '0;
      rdata <= '0;
    end else begin
      // Writes never target the front bank, so the read below cannot collide.
      if (we)
        mem[~front_sel][waddr] <= wdata;
      rdata <= mem[front_sel][raddr];
    end
  end

  assign pdata = mem[front_sel][paddr];

endmodule

// File: rtl/spectrum_frame_sched.sv
// Frame-synchronous scheduler between the FFT bin stream and the bar renderer.
// Ports: i_clk, reset (sync, active-high); s = bin stream slave;
// i_frame_start = vblank-start pulse; i_bar_idx -> o_bar_height/o_peak_height
// (1-cycle registered read); o_committed/o_stale/o_seq_err = 1-cycle pulses;
// o_state = current scheduler state for observation.
module spectrum_frame_sched
  import spectrum_frame_sched_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   reset,
  spectrum_frame_sched_if.slave  s,
  input  logic                   i_frame_start,
  input  logic [IDX_W-1:0]       i_bar_idx,
  output logic [H_W-1:0]         o_bar_height,
  output logic [H_W-1:0]         o_peak_height,
  output logic                   o_committed,
  output logic                   o_stale,
  output logic                   o_seq_err,
  output sched_state_e           o_state
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BARS - 1);

  sched_state_e     state, state_next;
  logic [IDX_W-1:0] idx, pidx;
  logic             bank;
  logic             wr_en, commit_next, stale_next, seq_err_next;
  logic [H_W-1:0]   peak_front;
  logic [H_W-1:0]   peak [N_BARS];

  assign s.ready = (state == FILL);
  assign o_state = state;

  always_ff @(posedge i_clk) begin
    if (reset) state <= FILL;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    wr_en        = 1'b0;
    commit_next  = 1'b0;
    stale_next   = 1'b0;
    seq_err_next = 1'b0;
    unique case (state)
      FILL: begin
        stale_next = i_frame_start;
        if (s.valid) begin
          wr_en = 1'b1;
          // The 32nd bin completes the set whether or not it carries last.
          if (idx == LAST_IDX) begin
            state_next   = READY;
            seq_err_next = !s.last;
          end else if (s.last) begin
            seq_err_next = 1'b1;
          end
        end
      end
      READY: begin
        if (i_frame_start) begin
          state_next  = SWAP;
          commit_next = 1'b1;
        end
      end
      SWAP: state_next = PEAK;
      PEAK: if (pidx == LAST_IDX) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      idx           <= '0;
      pidx          <= '0;
      bank          <= 1'b0;
      o_committed   <= 1'b0;
      o_stale       <= 1'b0;
      o_seq_err     <= 1'b0;
      o_peak_height <= '0;
      for (int i = 0; i < N_BARS; i++)
        peak[i] <= '0;
    end else begin
      o_committed   <= commit_next;
      o_stale       <= stale_next;
      o_seq_err     <= seq_err_next;
      o_peak_height <= peak[i_bar_idx];
      if (wr_en)
        idx <= (s.last || idx == LAST_IDX) ? '0 : idx + 1'b1;
      // Bank flips on the same edge o_committed rises, so the committed
      // cycle already sees the new front bank.
      if (commit_next)
        bank <= ~bank;
      if (state == SWAP)
        pidx <= '0;
      if (state == PEAK) begin
        peak[pidx] <= peak_next(peak_front, peak[pidx]);
        pidx       <= pidx + 1'b1;
        if (pidx == LAST_IDX)
          idx <= '0;
      end
    end
  end

  spectrum_frame_sched_bar_bank_rf u_rf (
    .i_clk     (i_clk),
    .reset     (reset),
    .front_sel (bank),
    .we        (wr_en),
    .waddr     (idx),
    .wdata     (bin_to_height(s.bin)),
    .raddr     (i_bar_idx),
    .rdata     (o_bar_height),
    .paddr     (pidx),
    .pdata     (peak_front)
  );

endmodule

// File: tb/tb_spectrum_frame_sched.sv
// Self-checking bench for spectrum_frame_sched: directed scenarios plus
// randomized frames, checked against a behavioural model of the frame banks.
module tb_spectrum_frame_sched;
  import spectrum_frame_sched_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic             frame_start;
  logic [IDX_W-1:0] bar_idx;
  logic [H_W-1:0]   bar_height, peak_height;
  logic             committed, stale, seq_err;
  sched_state_e     state;

  spectrum_frame_sched_if bus ();

  spectrum_frame_sched dut (
    .i_clk         (clk),
    .reset         (reset),
    .s             (bus),
    .i_frame_start (frame_start),
    .i_bar_idx     (bar_idx),
    .o_bar_height  (bar_height),
    .o_peak_height (peak_height),
    .o_committed   (committed),
    .o_stale       (stale),
    .o_seq_err     (seq_err),
    .o_state       (state)
  );

  // ---------------- reference model ----------------
  int m_front [N_BARS];
  int m_back  [N_BARS];
  int m_peak  [N_BARS];
  int m_idx;
  bit m_full;
  int set_v   [N_BARS];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic int ref_height(input int b);
    int q;
    if (b < 0) return 0;
    q = b / (2 ** SHIFT);
    return (q > MAX_H) ? MAX_H : q;
  endfunction

  function automatic int ref_peak(input int bar, input int pk);
    int d;
    d = pk - DECAY;
    if (d < 0) d = 0;
    return (bar > d) ? bar : d;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N_BARS; i++) begin
      m_front[i] = 0; m_back[i] = 0; m_peak[i] = 0;
    end
    m_idx  = 0;
    m_full = 1'b0;
  endtask

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    bus.valid   = 1'b0;
    bus.last    = 1'b0;
    frame_start = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    model_clear();
  endtask

  task automatic send_bin(input int b, input bit last, input bit fs);
    bit exp_err;
    check("ready_fill", 32'(bus.ready), 1);
    bus.valid   = 1'b1;
    bus.bin     = b[BIN_W-1:0];
    bus.last    = last;
    frame_start = fs;
    m_back[m_idx] = ref_height(b);
    if (m_idx == N_BARS - 1) begin
      m_full = 1'b1; exp_err = !last; m_idx = 0;
    end else if (last) begin
      exp_err = 1'b1; m_idx = 0;
    end else begin
      exp_err = 1'b0; m_idx++;
    end
    tick();
    bus.valid   = 1'b0;
    bus.last    = 1'b0;
    frame_start = 1'b0;
    check("seq_err", 32'(seq_err), 32'(exp_err));
    check("stale_on_bin", 32'(stale), 32'(fs));
    check("committed_on_bin", 32'(committed), 0);
  endtask

  // Sends set_v[0..N_BARS-1]; last_pos < 0 means no bin carries last.
  task automatic send_set(input int last_pos);
    for (int i = 0; i < N_BARS; i++) begin
      repeat ($urandom_range(0, 1)) tick();
      send_bin(set_v[i], i == last_pos, 1'b0);
    end
  endtask

  task automatic frame();
    int n;
    check("ready_before_fs", 32'(bus.ready), m_full ? 0 : 1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    if (m_full) begin
      check("committed", 32'(committed), 1);
      check("no_stale", 32'(stale), 0);
      for (int p = 0; p < N_BARS; p++) begin
        m_front[p] = m_back[p];
        m_peak[p]  = ref_peak(m_front[p], m_peak[p]);
      end
      m_full = 1'b0;
      n = 0;
      while (state != FILL && n < 100) begin
        tick();
        n++;
      end
      check("swap_to_fill_cycles", n, N_BARS + 1);
    end else begin
      check("stale", 32'(stale), 1);
      check("no_commit", 32'(committed), 0);
    end
  endtask

  task automatic read_one(input int i, output int bh, output int ph);
    bar_idx = i[IDX_W-1:0];
    tick();
    bh = int'(bar_height);
    ph = int'(peak_height);
  endtask

  task automatic check_reads();
    int bh, ph;
    for (int i = 0; i < N_BARS; i++) begin
      read_one(i, bh, ph);
      check($sformatf("bar_height[%0d]", i), bh, m_front[i]);
      check($sformatf("peak_height[%0d]", i), ph, m_peak[i]);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N_BARS; i++)
      set_v[i] = int'($urandom_range(0, 30000)) - 10000;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bh, ph;
    bus.bin  = '0;
    bar_idx  = '0;
    do_reset();

    // reset state
    check("rst_state", 32'(state), 32'(FILL));
    check("rst_ready", 32'(bus.ready), 1);
    check("rst_committed", 32'(committed), 0);
    check("rst_stale", 32'(stale), 0);
    check("rst_seq_err", 32'(seq_err), 0);
    check_reads();

    // 1: constant set clamps to MAX_H
    for (int i = 0; i < N_BARS; i++) set_v[i] = 15360;
    send_set(N_BARS - 1);
    frame();
    read_one(7, bh, ph);
    check("t1_bar7_479", bh, 479);
    check_reads();

    // 2: negative, huge and exact bins, random remainder
    fill_random();
    set_v[0] = -1000; set_v[1] = 32'h007F_FFFF; set_v[2] = 3200;
    send_set(N_BARS - 1);
    frame();
    read_one(0, bh, ph); check("t2_neg", bh, 0);
    read_one(1, bh, ph); check("t2_max", bh, 479);
    read_one(2, bh, ph); check("t2_3200", bh, 100);
    check_reads();

    // 3: frame_start with a partial set -> stale, then completion swaps
    fill_random();
    for (int i = 0; i < 20; i++) send_bin(set_v[i], 1'b0, 1'b0);
    frame();
    check_reads();
    for (int i = 20; i < N_BARS; i++) send_bin(set_v[i], i == N_BARS - 1, 1'b0);
    frame();
    check_reads();

    // 4: early last discards; next full set commits
    fill_random();
    for (int i = 0; i < 10; i++) send_bin(set_v[i], i == 9, 1'b0);
    fill_random();
    send_set(N_BARS - 1);
    frame();
    check_reads();
    // full set without last is still taken, with seq_err
    fill_random();
    send_set(-1);
    frame();
    check_reads();
    // final accept coincident with frame_start: stale, swap on next frame
    fill_random();
    for (int i = 0; i < N_BARS - 1; i++) send_bin(set_v[i], 1'b0, 1'b0);
    send_bin(set_v[N_BARS-1], 1'b1, 1'b1);
    check("t4_ready_after_coincident", 32'(bus.ready), 0);
    frame();
    check_reads();

    // 5: peak hold / decay
    do_reset();
    for (int i = 0; i < N_BARS; i++) set_v[i] = 0;
    set_v[0] = 400 * 32;
    send_set(N_BARS - 1);
    frame();
    read_one(0, bh, ph); check("t5_peak_400", ph, 400);
    set_v[0] = 100 * 32;
    for (int f = 1; f <= 3; f++) begin
      send_set(N_BARS - 1);
      frame();
      read_one(0, bh, ph);
      check($sformatf("t5_peak_f%0d", f), ph, 400 - 4 * f);
    end
    check_reads();
    do_reset();
    set_v[0] = 64;
    send_set(N_BARS - 1);
    frame();
    set_v[0] = 0;
    send_set(N_BARS - 1);
    frame();
    read_one(0, bh, ph); check("t5_peak_sat0", ph, 0);
    check_reads();

    // random frames
    for (int f = 0; f < 3; f++) begin
      fill_random();
      send_set(N_BARS - 1);
      frame();
      check_reads();
    end

    // 6: reset during the peak pass at pidx 10
    fill_random();
    send_set(N_BARS - 1);
    check("t6_ready_low", 32'(bus.ready), 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("t6_committed", 32'(committed), 1);
    repeat (11) tick();
    check("t6_in_peak", 32'(state), 32'(PEAK));
    reset = 1'b1;
    tick();
    check("t6_state_fill", 32'(state), 32'(FILL));
    check("t6_ready", 32'(bus.ready), 1);
    check("t6_bar_zero", 32'(bar_height), 0);
    check("t6_peak_zero", 32'(peak_height), 0);
    reset = 1'b0;
    model_clear();
    check_reads();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
